sa_job_scheduler: RTL

//  Sequences one matrix-multiply job on the tiled systolic array: latches tile mode, runs the operand feed

---
 rtl/sa_pkg.sv | 26 ++
 rtl/sa_down_counter.sv | 38 +++
 rtl/sa_job_scheduler.sv | 120 ++++++++++++
 3 files changed

// File: rtl/sa_pkg.sv
// Shared definitions for the systolic-array job scheduler:
// state encoding, tile-mode constants and flush-length derivation.
package sa_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FEED,
        ST_FLUSH,
        ST_CAPTURE,
        ST_DRAIN,
        ST_DONE
    } sa_state_e;

    localparam logic [4:0] TILE_MONO = 5'b00000;
    localparam logic [4:0] TILE_QUAD = 5'b11111;

    localparam int TOTAL_SIZE_DEF = 32;

    // Skewed pipeline: last operand reaches the far corner PE after 2*N-1 cycles.
    function automatic int flush_cycles(input int total_size);
        return 2 * total_size - 1;
    endfunction

    localparam int FLUSH_CYCLES_DEF = flush_cycles(TOTAL_SIZE_DEF);

endpackage

// File: rtl/sa_down_counter.sv
// Loadable saturating down counter with a zero flag.
// Load has priority over decrement; decrement stops at zero.
module sa_down_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         zero
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    // Next count: reload, step down, or hold at zero.
    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (dec && (count_q != '0)) begin
            count_d = count_q - W'(1);
        end
    end

    // Count register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign zero = (count_q == '0);

endmodule

// File: rtl/sa_job_scheduler.sv
// Job sequencer for the tiled systolic array: feed, flush,
// capture, then drain the serializers under backpressure.
import sa_pkg::*;

module sa_job_scheduler #(
    parameter int TOTAL_SIZE = TOTAL_SIZE_DEF,
    parameter int K_WIDTH    = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cfg_valid,
    output logic               cfg_ready,
    input  logic [4:0]         cfg_tile,
    input  logic [K_WIDTH-1:0] cfg_k,
    output logic               feed_en,
    output logic               feed_last,
    output logic [4:0]         tile_signal,
    output logic               pass_w_enable,
    output logic               pass_r_enable,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               out_last,
    output logic               busy,
    output logic               done
);

    localparam int FLUSH_CYCLES = flush_cycles(TOTAL_SIZE);
    localparam int CW = $clog2(FLUSH_CYCLES + 1);
    localparam logic [CW-1:0] FLUSH_LOAD = CW'(FLUSH_CYCLES - 1);
    localparam logic [CW-1:0] DRAIN_LOAD = CW'(TOTAL_SIZE - 1);

    sa_state_e  state_q;
    logic [4:0] tile_q;

    logic accept;
    logic handshake;
    logic beat_zero;
    logic flush_zero;
    logic drain_zero;

    assign accept    = cfg_valid && (state_q == ST_IDLE);
    assign handshake = (state_q == ST_DRAIN) && out_ready;

    // Counters hold "beats remaining minus one", so zero marks the last beat.
    sa_down_counter #(.W(K_WIDTH)) u_beat (
        .clk      (clk),
        .rst      (rst),
        .load     (accept),
        .load_val (cfg_k - K_WIDTH'(1)),
        .dec      (state_q == ST_FEED),
        .zero     (beat_zero)
    );

    sa_down_counter #(.W(CW)) u_flush (
        .clk      (clk),
        .rst      (rst),
        .load     ((state_q == ST_FEED) && beat_zero),
        .load_val (FLUSH_LOAD),
        .dec      (state_q == ST_FLUSH),
        .zero     (flush_zero)
    );

    sa_down_counter #(.W(CW)) u_drain (
        .clk      (clk),
        .rst      (rst),
        .load     (state_q == ST_CAPTURE),
        .load_val (DRAIN_LOAD),
        .dec      (handshake),
        .zero     (drain_zero)
    );

    // Job FSM; tile mode is latched on accept and cleared on return to idle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            tile_q  <= '0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (cfg_valid) begin
                        tile_q  <= cfg_tile;
                        state_q <= (cfg_k == '0) ? ST_DONE : ST_FEED;
                    end
                end
                ST_FEED: begin
                    if (beat_zero) state_q <= ST_FLUSH;
                end
                ST_FLUSH: begin
                    if (flush_zero) state_q <= ST_CAPTURE;
                end
                ST_CAPTURE: begin
                    state_q <= ST_DRAIN;
                end
                ST_DRAIN: begin
                    if (out_ready && drain_zero) state_q <= ST_DONE;
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                    tile_q  <= '0;
                end
                default: begin
                    state_q <= ST_IDLE;
                    tile_q  <= '0;
                end
            endcase
        end
    end

    assign cfg_ready     = (state_q == ST_IDLE);
    assign busy          = (state_q != ST_IDLE);
    assign done          = (state_q == ST_DONE);
    assign feed_en       = (state_q == ST_FEED);
    assign feed_last     = (state_q == ST_FEED) && beat_zero;
    assign pass_w_enable = (state_q == ST_CAPTURE);
    assign out_valid     = (state_q == ST_DRAIN);
    assign out_last      = (state_q == ST_DRAIN) && drain_zero;
    assign pass_r_enable = handshake;
    assign tile_signal   = tile_q;

endmodule
